// File: rtl/mux8_bus_arbiter.sv
// Round-robin arbiter for an 8-input, 16-bit shared mux with bounded bursts.
// Define ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 highest).
module mux8_bus_arbiter #(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       bus_ready,
    output logic [2:0] select,
    output logic [7:0] grant,
    output logic       bus_valid,
    output logic       beat_done
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [7:0]       r_grant;
    logic [7:0]       w_grant_nx;
    logic [2:0]       r_select;
    logic [2:0]       w_select_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_done;
    logic             w_done_nx;

    logic [2:0]       w_base;
    logic [7:0]       w_arb_req;
    logic             w_win;
    logic [2:0]       w_win_idx;
    logic             w_hs;
    logic             w_rel_a;
    logic             w_rel_b;
    logic             w_last;

    // Scan base, base+1, ... ; the lowest offset with a request wins.
    function automatic logic [3:0] f_pick(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign bus_valid = (r_state == S_BUSY) && ((r_grant & req) != 8'h00);
    assign w_hs      = bus_valid & bus_ready;
    assign w_rel_a   = ~req[r_select];
    assign w_last    = (r_cnt == CNT_W'(MAX_BEATS - 1));
    assign w_rel_b   = w_hs & w_last;

    // A dropped owner must not win the back-to-back arbitration it caused.
    assign w_arb_req = ((r_state == S_BUSY) && w_rel_a) ? (req & ~r_grant) : req;

`ifdef ARB_FIXED_PRIORITY_EN
    assign w_base = 3'd0;
`else
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nx;

    assign w_base = (r_state == S_BUSY) ? (r_select + 3'd1) : r_ptr;
`endif

    assign {w_win, w_win_idx} = f_pick(w_arb_req, w_base);

    always_comb begin
        w_state_nx  = r_state;
        w_grant_nx  = r_grant;
        w_select_nx = r_select;
        w_cnt_nx    = r_cnt;
        w_done_nx   = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
        w_ptr_nx    = r_ptr;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_win) begin
                    w_grant_nx  = 8'(1) << w_win_idx;
                    w_select_nx = w_win_idx;
                    w_cnt_nx    = '0;
                    w_state_nx  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_rel_a || w_rel_b) begin
                    w_done_nx = 1'b1;
                    w_cnt_nx  = '0;
`ifndef ARB_FIXED_PRIORITY_EN
                    w_ptr_nx  = r_select + 3'd1;
`endif
                    if (w_win) begin
                        w_grant_nx  = 8'(1) << w_win_idx;
                        w_select_nx = w_win_idx;
                    end else begin
                        w_grant_nx = 8'h00;
                        w_state_nx = S_IDLE;
                    end
                end else if (w_hs) begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= 8'h00;
            r_select <= 3'd0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            r_ptr    <= 3'd0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_grant  <= w_grant_nx;
            r_select <= w_select_nx;
            r_cnt    <= w_cnt_nx;
            r_done   <= w_done_nx;
`ifndef ARB_FIXED_PRIORITY_EN
            r_ptr    <= w_ptr_nx;
`endif
        end
    end

    assign grant     = r_grant;
    assign select    = r_select;
    assign beat_done = r_done;

endmodule
